xcorr_sweep_ctrl: RTL and testbench

- Sequencer for the microphone-pair cross-correlation datapath in the audio_process subsystem.
- On each ready frame it pulls one frame from the mic FIFOs, then runs the XCORR core once per lag from -LAGNUM to +LAGNUM.
- It tracks the peak of |xcorr| over the sweep and publishes the winning lag to the beamforming/display logic.
- It replaces ad-hoc start/peak logic and adds a done-timeout guard.

---
 rtl/xcorr_sweep_ctrl.sv | 149 ++++++++++++++
 tb/tb_xcorr_sweep_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/xcorr_sweep_ctrl.sv
// rtl/xcorr_sweep_ctrl.sv - frame load and lag sweep sequencer for the mic-pair XCORR core
module xcorr_sweep_ctrl #(
    parameter int LAGNUM    = 10,
    parameter int FRAME_LEN = 256,
    parameter int TIMEOUT   = 4096
) (
    input  logic               clk_60MHz,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_rdy,
    output logic               fifo_rd_en,
    output logic               xcorr_start,
    output logic signed [5:0]  xcorr_lag,
    input  logic               xcorr_done,
    input  logic signed [32:0] xcorr_data,
    output logic signed [5:0]  lag_diff,
    output logic [32:0]        peak_mag,
    output logic               lag_valid,
    output logic               busy,
    output logic               timeout_err
);

    localparam int SW = $clog2(FRAME_LEN);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0]     SCNT_LAST = SW'(FRAME_LEN - 1);
    localparam logic [TW-1:0]     TCNT_LAST = TW'(TIMEOUT - 1);
    localparam logic signed [5:0] LAG_FIRST = 6'(-LAGNUM);
    localparam logic signed [5:0] LAG_LAST  = 6'(LAGNUM);
    localparam logic [32:0]        MAG_SAT  = {1'b0, {32{1'b1}}};
    localparam logic signed [32:0] DATA_MIN = {1'b1, 32'd0};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [SW-1:0]     scnt_q, scnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic signed [5:0] cur_lag_q, cur_lag_d;
    logic [32:0]       run_max_q, run_max_d;
    logic signed [5:0] run_lag_q, run_lag_d;
    logic signed [5:0] lag_diff_q, lag_diff_d;
    logic [32:0]       peak_mag_q, peak_mag_d;
    logic [32:0]       mag;
    logic              take_peak;
    logic              timeout_hit;

    // -2^32 has no positive 33-bit counterpart worth publishing, so clamp it.
    always_comb begin
        if (xcorr_data == DATA_MIN) begin
            mag = MAG_SAT;
        end else if (xcorr_data[32]) begin
            mag = $unsigned(-xcorr_data);
        end else begin
            mag = $unsigned(xcorr_data);
        end
    end

    assign take_peak = (cur_lag_q == LAG_FIRST) || (mag > run_max_q);

    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        tcnt_d      = tcnt_q;
        cur_lag_d   = cur_lag_q;
        run_max_d   = run_max_q;
        run_lag_d   = run_lag_q;
        lag_diff_d  = lag_diff_q;
        peak_mag_d  = peak_mag_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && frame_rdy) begin
                    state_d = S_LOAD;
                    scnt_d  = '0;
                end
            end
            S_LOAD: begin
                scnt_d = scnt_q + 1'b1;
                if (scnt_q == SCNT_LAST) begin
                    state_d   = S_START;
                    cur_lag_d = LAG_FIRST;
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done in the limit cycle takes priority over the timeout.
                if (xcorr_done) begin
                    if (take_peak) begin
                        run_max_d = mag;
                        run_lag_d = cur_lag_q;
                    end
                    if (cur_lag_q == LAG_LAST) begin
                        state_d    = S_DONE;
                        lag_diff_d = run_lag_d;
                        peak_mag_d = run_max_d;
                    end else begin
                        cur_lag_d = cur_lag_q + 6'sd1;
                        state_d   = S_START;
                    end
                end else if (tcnt_q == TCNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_60MHz) begin
        if (rst) begin
            state_q    <= S_IDLE;
            scnt_q     <= '0;
            tcnt_q     <= '0;
            cur_lag_q  <= '0;
            run_max_q  <= '0;
            run_lag_q  <= '0;
            lag_diff_q <= '0;
            peak_mag_q <= '0;
        end else begin
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            tcnt_q     <= tcnt_d;
            cur_lag_q  <= cur_lag_d;
            run_max_q  <= run_max_d;
            run_lag_q  <= run_lag_d;
            lag_diff_q <= lag_diff_d;
            peak_mag_q <= peak_mag_d;
        end
    end

    assign fifo_rd_en  = (state_q == S_LOAD);
    assign xcorr_start = (state_q == S_START);
    assign xcorr_lag   = cur_lag_q;
    assign lag_diff    = lag_diff_q;
    assign peak_mag    = peak_mag_q;
    assign lag_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_xcorr_sweep_ctrl.sv
// tb/tb_xcorr_sweep_ctrl.sv - directed self-checking bench for xcorr_sweep_ctrl
module tb_xcorr_sweep_ctrl;

    localparam int LAGNUM    = 2;
    localparam int FRAME_LEN = 4;
    localparam int TIMEOUT   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               frame_rdy;
    logic               fifo_rd_en;
    logic               xcorr_start;
    logic signed [5:0]  xcorr_lag;
    logic               xcorr_done;
    logic signed [32:0] xcorr_data;
    logic signed [5:0]  lag_diff;
    logic [32:0]        peak_mag;
    logic               lag_valid;
    logic               busy;
    logic               timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    logic signed [32:0] res [5];

    xcorr_sweep_ctrl #(
        .LAGNUM    (LAGNUM),
        .FRAME_LEN (FRAME_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_60MHz   (clk),
        .rst         (rst),
        .enable      (enable),
        .frame_rdy   (frame_rdy),
        .fifo_rd_en  (fifo_rd_en),
        .xcorr_start (xcorr_start),
        .xcorr_lag   (xcorr_lag),
        .xcorr_done  (xcorr_done),
        .xcorr_data  (xcorr_data),
        .lag_diff    (lag_diff),
        .peak_mag    (peak_mag),
        .lag_valid   (lag_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_res(input longint a, input longint b, input longint c, input longint d, input longint e);
        res[0] = 33'(a);
        res[1] = 33'(b);
        res[2] = 33'(c);
        res[3] = 33'(d);
        res[4] = 33'(e);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd"},    64'(fifo_rd_en),  64'd0);
        check_eq({tag, "_start"}, 64'(xcorr_start), 64'd0);
        check_eq({tag, "_lag"},   64'(xcorr_lag),   64'd0);
        check_eq({tag, "_ldiff"}, 64'(lag_diff),    64'd0);
        check_eq({tag, "_pmag"},  64'(peak_mag),    64'd0);
        check_eq({tag, "_valid"}, 64'(lag_valid),   64'd0);
        check_eq({tag, "_busy"},  64'(busy),        64'd0);
        check_eq({tag, "_tout"},  64'(timeout_err), 64'd0);
    endtask

    // hold_idx: run whose done is withheld; slow_idx: run whose done lands in the limit cycle;
    // abort_idx: run during whose WAIT reset is applied.
    task automatic run_sweep(input string tag, input int hold_idx, input int slow_idx, input int abort_idx,
                             input int exp_nstart, input int exp_valid, input int exp_vcyc,
                             input int exp_to, input longint exp_lag, input longint exp_mag);
        int cyc = 0, nrd = 0, first_rd = -1, last_rd = -1, nstart = 0, start_cyc = 0, pend_idx = 0;
        int n_valid = 0, valid_cyc = -1, n_to = 0, to_off = -1, first_start = -1;
        bit pending = 0, both = 0;
        logic signed [5:0] lags [5];
        for (int i = 0; i < 5; i++) lags[i] = '0;
        enable = 1'b1;
        frame_rdy = 1'b1;
        while (cyc < 600 && n_valid == 0 && n_to == 0) begin
            @(posedge clk); #1;
            cyc++;
            xcorr_done = 1'b0;
            if (pending && pend_idx != hold_idx &&
                cyc == start_cyc + ((pend_idx == slow_idx) ? TIMEOUT : 2)) begin
                xcorr_done = 1'b1;
                xcorr_data = res[pend_idx];
                pending    = 0;
            end
            #1;
            if (fifo_rd_en) begin
                nrd++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                frame_rdy = 1'b0;
            end
            if (xcorr_start) begin
                if (fifo_rd_en) both = 1;
                if (nstart < 5) lags[nstart] = xcorr_lag;
                if (first_start < 0) first_start = cyc;
                start_cyc = cyc;
                pend_idx  = nstart;
                pending   = 1;
                nstart++;
            end
            if (lag_valid) begin
                n_valid++;
                valid_cyc = cyc;
            end
            if (timeout_err) begin
                n_to++;
                to_off = cyc - start_cyc;
            end
            if (abort_idx >= 0 && pending && pend_idx == abort_idx && cyc == start_cyc + 1) begin
                check_eq({tag, "_busy_pre"}, 64'(busy), 64'd1);
                rst = 1'b1;
                enable = 1'b0;
                frame_rdy = 1'b0;
                @(posedge clk); #1;
                check_all_zero({tag, "_rst"});
                rst = 1'b0;
                return;
            end
        end
        enable = 1'b0;
        frame_rdy = 1'b0;
        xcorr_done = 1'b0;
        check_eq({tag, "_nrd"},      64'(nrd), 64'(FRAME_LEN));
        check_eq({tag, "_rd_first"}, 64'(first_rd), 64'd1);
        check_eq({tag, "_rd_last"},  64'(last_rd), 64'(FRAME_LEN));
        check_eq({tag, "_st_first"}, 64'(first_start), 64'(FRAME_LEN + 1));
        check_eq({tag, "_overlap"},  64'(both), 64'd0);
        check_eq({tag, "_nstart"},   64'(nstart), 64'(exp_nstart));
        for (int i = 0; i < 5; i++)
            if (i < nstart) check_eq($sformatf("%s_lag%0d", tag, i), 64'(lags[i]), 64'(i - LAGNUM));
        check_eq({tag, "_nvalid"}, 64'(n_valid), 64'(exp_valid));
        check_eq({tag, "_ntout"},  64'(n_to), 64'(exp_to));
        if (exp_valid != 0) check_eq({tag, "_vcyc"}, 64'(valid_cyc), 64'(exp_vcyc));
        if (exp_to != 0) check_eq({tag, "_toff"}, 64'(to_off), 64'(TIMEOUT));
        check_eq({tag, "_ldiff"}, 64'(lag_diff), 64'(exp_lag));
        check_eq({tag, "_pmag"},  64'(peak_mag), 64'(exp_mag));
        @(posedge clk); #1;
        check_eq({tag, "_busy_end"},  64'(busy), 64'd0);
        check_eq({tag, "_valid_end"}, 64'(lag_valid), 64'd0);
        check_eq({tag, "_ldiff_hold"}, 64'(lag_diff), 64'(exp_lag));
    endtask

    initial begin
        int nrd, nbusy;
        rst = 1'b1;
        enable = 1'b0;
        frame_rdy = 1'b0;
        xcorr_done = 1'b0;
        xcorr_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            xcorr_done = i[0];
            xcorr_data = 33'sd77;
        end
        @(posedge clk); #1;
        check_all_zero("reset");
        rst = 1'b0;

        frame_rdy = 1'b1;
        nrd = 0;
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            xcorr_done = i[0];
            @(posedge clk); #1;
            if (fifo_rd_en) nrd++;
            if (busy) nbusy++;
        end
        xcorr_done = 1'b0;
        frame_rdy = 1'b0;
        check_eq("no_enable_rd", 64'(nrd), 64'd0);
        check_eq("no_enable_busy", 64'(nbusy), 64'd0);

        set_res(5, -40, 100, 7, 99);
        run_sweep("normal", -1, -1, -1, 5, 1, 20, 0, 0, 100);

        set_res(50, 80, -80, 10, 3);
        run_sweep("tie", -1, -1, -1, 5, 1, 20, 0, -1, 80);

        set_res(1, 2, 3, -64'sd4294967296, 4);
        run_sweep("sat", -1, -1, -1, 5, 1, 20, 0, 1, 64'hFFFF_FFFF);

        set_res(1, 2, 3, 4, 5);
        run_sweep("timeout", 2, -1, -1, 3, 0, -1, 1, 1, 64'hFFFF_FFFF);

        set_res(1, 2, 300, 4, 5);
        run_sweep("limit", -1, 2, -1, 5, 1, 34, 0, 0, 300);

        set_res(5, -40, 100, 7, 99);
        run_sweep("abort", -1, -1, 1, 0, 0, -1, 0, 0, 0);
        run_sweep("after_rst", -1, -1, -1, 5, 1, 20, 0, 0, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
